// File: rtl/la_ioring_seq_pkg.sv
// la_ioring_seq_pkg: state encoding and timer sizing shared by the IO ring sequencer
package la_ioring_seq_pkg;
  typedef enum logic [2:0] {
    OFF   = 3'd0,
    UP    = 3'd1,
    ON    = 3'd2,
    DOWN  = 3'd3,
    FAULT = 3'd4
  } state_t;
  function automatic int timer_w(input int delay);
    return (delay > 1) ? $clog2(delay) : 1;
  endfunction
endpackage

// File: rtl/la_ioring_seq_timer.sv
// la_ioring_seq_timer: loadable down-counter that parks at zero and flags it
module la_ioring_seq_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] init,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) cnt <= '0;
    else if (load) cnt <= init;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/la_ioring_seq.sv
// la_ioring_seq: steps the IO ring control bus up/down one bit per DELAY cycles with fault shutdown
module la_ioring_seq
  import la_ioring_seq_pkg::*;
#(
  parameter int RINGW = 8,
  parameter int DELAY = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req,
  input  logic             fault,
  output logic [RINGW-1:0] ioring,
  output logic             ack,
  output logic             busy,
  output logic             faulted
);
  localparam int TW = timer_w(DELAY);
  localparam int IW = $clog2(RINGW + 1);
  localparam logic [IW-1:0] FULL = IW'(RINGW);
  state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic step, load, zero;
  la_ioring_seq_timer #(.W(TW)) u_timer (
    .clk(clk),
    .nreset(nreset),
    .load(load),
    .init(TW'(DELAY - 1)),
    .zero(zero)
  );
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= OFF;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  // A direction change outranks a coincident timer expiry, so no bit moves on that edge.
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    step = 1'b0;
    if (fault) begin
      state_nx = FAULT;
      idx_nx = '0;
    end else
      case (state)
        OFF: if (req) state_nx = UP;
        UP:
          if (!req) state_nx = (idx == '0) ? OFF : DOWN;
          else if (zero) begin
            step = 1'b1;
            idx_nx = idx + IW'(1);
            if (idx_nx == FULL) state_nx = ON;
          end
        ON: if (!req) state_nx = DOWN;
        DOWN:
          if (req) state_nx = (idx == FULL) ? ON : UP;
          else if (zero) begin
            step = 1'b1;
            idx_nx = idx - IW'(1);
            if (idx_nx == '0) state_nx = OFF;
          end
        FAULT: if (!req) state_nx = OFF;
        default: begin
          state_nx = OFF;
          idx_nx = '0;
        end
      endcase
  end
  always_comb begin
    ack = (state == ON) && (idx == FULL);
    busy = (state == UP) || (state == DOWN);
    faulted = (state == FAULT);
    load = step || (state_nx != state);
  end
  for (genvar i = 0; i < RINGW; i++) begin : g_therm
    assign ioring[i] = (idx > IW'(i));
  end
endmodule
